// File: rtl/es4_video_pkg.sv
// Shared video types for the ES4 VGA lab: visible geometry, coordinate type,
// box scheduler state encoding and the modular position update.
package es4_video_pkg;

   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      RUN,
      UPDATE,
      PAUSE
   } sched_state_t;

   // y + step folded back into [0, modulus); valid while y < modulus and step <= modulus.
   function automatic coord_t wrap_add(coord_t y, coord_t step, coord_t modulus);
      logic [10:0] w_sum;
      w_sum = {1'b0, y} + {1'b0, step};
      if (w_sum >= {1'b0, modulus}) begin
         w_sum = w_sum - {1'b0, modulus};
      end
      return w_sum[9:0];
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // NOTE: non-blocking assignments make every flop sample the pre-edge value,
   // so the chain shifts one stage per clock regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/box_motion_scheduler.sv
// Frame-synchronous owner of the animated box positions: one update pass per
// frame tick, one box per cycle, with pause/resume, speed select and restart.
module box_motion_scheduler
   import es4_video_pkg::*;
#(
   parameter int NUM_BOXES = 4,
   parameter int V_WRAP    = V_VISIBLE,
   parameter int SPACING   = 125,
   parameter int TICK_ROW  = 486
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  coord_t                  Row,
   input  coord_t                  Col,
   input  logic                    btn_pause,
   input  logic                    restart,
   input  logic [1:0]              speed_sel,
   output coord_t [NUM_BOXES-1:0]  y_pos,
   output logic                    running,
   output logic                    frame_done,
   output logic [7:0]              frame_cnt
);

   localparam int IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);

   sched_state_t      r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [3:0]        r_step;
   logic              r_pend_pause;
   logic              w_tick;
   logic              w_pause_edge;

   function automatic coord_t init_pos(int i);
      return coord_t'((i * SPACING) % V_WRAP);
   endfunction

   assign w_tick = (Row == coord_t'(TICK_ROW)) && (Col == '0);

   btn_sync_edge u_pause_sync (
      .clk     (CLK),
      .rst_n   (RST_N),
      .i_async (btn_pause),
      .o_rise  (w_pause_edge)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: y_pos is a handful of flops, not a RAM, so it takes a real
         // per-element reset value rather than being left uninitialised.
         for (int i = 0; i < NUM_BOXES; i++) begin
            y_pos[i] <= init_pos(i);
         end
         r_state      <= RUN;
         r_idx        <= '0;
         r_step       <= 4'd1;
         r_pend_pause <= 1'b0;
         running      <= 1'b1;
         frame_done   <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         if (restart) begin
            // Restart wins over tick and pause_edge; PAUSE is kept, a pass is aborted.
            for (int i = 0; i < NUM_BOXES; i++) begin
               y_pos[i] <= init_pos(i);
            end
            r_idx        <= '0;
            r_pend_pause <= 1'b0;
            frame_cnt    <= '0;
            if (r_state == UPDATE) begin
               r_state <= RUN;
               running <= 1'b1;
            end
         end else begin
            case (r_state)
               RUN: begin
                  if (w_pause_edge) begin
                     r_state <= PAUSE;
                     running <= 1'b0;
                  end else if (w_tick) begin
                     r_state      <= UPDATE;
                     r_idx        <= '0;
                     r_step       <= 4'd1 << speed_sel;
                     r_pend_pause <= 1'b0;
                  end
               end
               UPDATE: begin
                  for (int i = 0; i < NUM_BOXES; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        y_pos[i] <= wrap_add(y_pos[i], coord_t'(r_step), coord_t'(V_WRAP));
                     end
                  end
                  if (r_idx == LAST_IDX) begin
                     r_idx        <= '0;
                     r_pend_pause <= 1'b0;
                     frame_done   <= 1'b1;
                     frame_cnt    <= frame_cnt + 8'd1;
                     if (r_pend_pause || w_pause_edge) begin
                        r_state <= PAUSE;
                        running <= 1'b0;
                     end else begin
                        r_state <= RUN;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     if (w_pause_edge) begin
                        r_pend_pause <= 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (w_pause_edge) begin
                     r_state <= RUN;
                     running <= 1'b1;
                  end
               end
               default: begin
                  r_state <= RUN;
                  running <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_box_motion_scheduler.sv
// Directed bench for box_motion_scheduler: a position model feeds a scoreboard
// of expected per-pass results, compared whenever the DUT pulses frame_done.
module tb_box_motion_scheduler;
   import es4_video_pkg::*;

   localparam int NB       = 4;
   localparam int TICK_ROW = 486;

   typedef logic [NB-1:0][9:0] yvec_t;
   typedef struct {
      yvec_t      y;
      logic [7:0] cnt;
   } exp_t;

   logic                CLK = 1'b0;
   logic                RST_N;
   coord_t              Row;
   coord_t              Col;
   logic                btn_pause;
   logic                restart;
   logic [1:0]          speed_sel;
   coord_t [NB-1:0]     y_pos;
   logic                running;
   logic                frame_done;
   logic [7:0]          frame_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned m_y [NB];
   logic [7:0]  m_cnt;
   bit          m_paused;
   exp_t        sb_q [$];

   always #5 CLK = ~CLK;

   box_motion_scheduler dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .Row        (Row),
      .Col        (Col),
      .btn_pause  (btn_pause),
      .restart    (restart),
      .speed_sel  (speed_sel),
      .y_pos      (y_pos),
      .running    (running),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic yvec_t mk(int a, int b, int c, int d);
      yvec_t v;
      v[0] = 10'(a);
      v[1] = 10'(b);
      v[2] = 10'(c);
      v[3] = 10'(d);
      return v;
   endfunction

   function automatic yvec_t model_vec();
      yvec_t v;
      for (int i = 0; i < NB; i++) v[i] = 10'(m_y[i]);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m_y[i] = (i * 125) % 480;
      m_cnt = 8'd0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge CLK);
   endtask

   // One frame tick; expect_pass=0 when the bench knows the pass will be aborted.
   task automatic tick(bit expect_pass = 1'b1, bit press = 1'b0);
      int unsigned step;
      @(negedge CLK);
      Row = coord_t'(TICK_ROW);
      Col = '0;
      if (press) btn_pause = 1'b1;
      if (expect_pass && !m_paused) begin
         step = 1 << speed_sel;
         for (int i = 0; i < NB; i++) m_y[i] = (m_y[i] + step) % 480;
         m_cnt = m_cnt + 8'd1;
         sb_q.push_back('{model_vec(), m_cnt});
      end
      @(negedge CLK);
      Row = '0;
      Col = 10'd5;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RST_N === 1'b1 && frame_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL unexpected_frame_done: observed 1 expected 0");
         end else begin
            e = sb_q.pop_front();
            check("pass_y_pos", 64'(y_pos), 64'(e.y));
            check("pass_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
         end
      end
   end

   initial begin
      int fd_at;
      int fd_n;
      yvec_t held_y;
      logic [7:0] held_cnt;

      RST_N = 1'b0; Row = '0; Col = 10'd5;
      btn_pause = 1'b0; restart = 1'b0; speed_sel = 2'd0;
      m_paused = 1'b0;
      model_reset();
      idle(3);
      check("rst_y_pos", 64'(y_pos), 64'(mk(0, 125, 250, 375)));
      check("rst_running", 64'(running), 64'd1);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      idle(2);

      // First frame at speed 1, with frame_done latency measured from the tick cycle.
      check("pre_tick_y_pos", 64'(y_pos), 64'(mk(0, 125, 250, 375)));
      tick();
      fd_at = -1;
      fd_n  = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge CLK);
         if (frame_done === 1'b1) begin
            fd_n++;
            if (fd_at < 0) fd_at = k + 1;
         end
      end
      check("frame_done_latency", 64'(fd_at), 64'd5);
      check("frame_done_width", 64'(fd_n), 64'd1);
      check("first_y_pos", 64'(y_pos), 64'(mk(1, 126, 251, 376)));
      check("first_frame_cnt", 64'(frame_cnt), 64'd1);

      // Restart, then preload 119 frames at speed 4 to sit just below the wrap.
      @(negedge CLK);
      restart = 1'b1;
      model_reset();
      @(negedge CLK);
      restart = 1'b0;
      speed_sel = 2'd2;
      repeat (119) begin
         tick();
         idle(6);
      end
      check("preload_y0", 64'(y_pos[0]), 64'd476);
      check("preload_y3", 64'(y_pos[3]), 64'd371);
      tick();
      idle(6);
      check("wrap_y0", 64'(y_pos[0]), 64'd0);

      // Pause from the button: three-cycle synchronizer path, ticks then ignored.
      @(negedge CLK);
      btn_pause = 1'b1;
      idle(2);
      check("pause_running_cycle2", 64'(running), 64'd1);
      idle(1);
      check("pause_running_cycle3", 64'(running), 64'd0);
      m_paused = 1'b1;
      idle(17);
      btn_pause = 1'b0;
      held_y   = model_vec();
      held_cnt = m_cnt;
      repeat (3) begin
         tick();
         idle(6);
      end
      check("paused_y_pos", 64'(y_pos), 64'(held_y));
      check("paused_frame_cnt", 64'(frame_cnt), 64'(held_cnt));
      btn_pause = 1'b1;
      idle(3);
      check("resume_running", 64'(running), 64'd1);
      m_paused = 1'b0;
      idle(17);
      btn_pause = 1'b0;
      idle(4);
      tick();
      idle(6);

      // Pause edge lands in cycle t+2 of a pass: pass completes, then PAUSE.
      tick(1'b1, 1'b1);
      idle(3);
      check("midpass_pause_running_t4", 64'(running), 64'd1);
      idle(1);
      check("midpass_pause_frame_done", 64'(frame_done), 64'd1);
      check("midpass_pause_running_t5", 64'(running), 64'd0);
      m_paused = 1'b1;
      idle(16);
      btn_pause = 1'b0;
      idle(4);
      btn_pause = 1'b1;
      idle(3);
      check("midpass_resume_running", 64'(running), 64'd1);
      m_paused = 1'b0;
      idle(10);
      btn_pause = 1'b0;
      idle(4);

      // Restart in cycle t+3 aborts the pass with no frame_done.
      tick(1'b0);
      idle(1);
      @(negedge CLK);
      restart = 1'b1;
      model_reset();
      @(negedge CLK);
      restart = 1'b0;
      check("restart_y_pos", 64'(y_pos), 64'(mk(0, 125, 250, 375)));
      check("restart_frame_cnt", 64'(frame_cnt), 64'd0);
      check("restart_running", 64'(running), 64'd1);
      idle(6);
      tick();
      idle(6);
      check("sb_drained_mid", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset between clock edges in the middle of a pass.
      tick();
      @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check("async_rst_y_pos", 64'(y_pos), 64'(mk(0, 125, 250, 375)));
      check("async_rst_running", 64'(running), 64'd1);
      check("async_rst_frame_done", 64'(frame_done), 64'd0);
      check("async_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      sb_q.delete();
      model_reset();
      idle(2);
      @(negedge CLK);
      RST_N = 1'b1;
      idle(2);

      // 256 passes with speed_sel changed right after each tick: cnt wraps to 0.
      for (int p = 0; p < 256; p++) begin
         speed_sel = 2'($urandom_range(0, 3));
         tick();
         speed_sel = speed_sel + 2'd1;
         idle(6);
      end
      check("cnt_wrap", 64'(frame_cnt), 64'd0);
      check("sb_drained_end", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
